// File: rtl/tdc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tdc_pkg
// Brief    : Shared widths, helpers and record type for the TDC stamp engine.
// Revision : 1.0
// ============================================================================
package tdc_pkg;

   // Record fields are sized for the largest supported configuration; the
   // engine zero-extends into them and slices back out on the output side.
   localparam int TDC_MAX_CH_W     = 8;
   localparam int TDC_MAX_COARSE_W = 32;
   localparam int TDC_MAX_FINE_W   = 11;

   function automatic int tdc_fine_w(input int num_taps);
      return $clog2(num_taps + 1);
   endfunction

   function automatic int tdc_ch_w(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

   typedef struct packed {
      logic [TDC_MAX_CH_W-1:0]     channel;
      logic [TDC_MAX_COARSE_W-1:0] coarse;
      logic [TDC_MAX_FINE_W-1:0]   fine;
   } tdc_rec_t;

endpackage
`default_nettype wire

// File: rtl/tdc_therm2bin.sv
`default_nettype none
// ============================================================================
// Module   : tdc_therm2bin
// Brief    : Bubble-tolerant thermometer decode as a plain ones count.
// Revision : 1.0
// ============================================================================
module tdc_therm2bin
   import tdc_pkg::*;
#(
   parameter  int NUM_TAPS = 32,
   localparam int FINE_W   = tdc_fine_w(NUM_TAPS)
) (
   input  logic [NUM_TAPS-1:0] i_therm,
   output logic [FINE_W-1:0]   o_count
);

   always_comb begin
      o_count = '0;
      for (int i = 0; i < NUM_TAPS; i++) begin
         o_count = o_count + FINE_W'(i_therm[i]);
      end
   end

endmodule
`default_nettype wire

// File: rtl/tdc_stamp_engine.sv
`default_nettype none
// ============================================================================
// Module   : tdc_stamp_engine
// Brief    : Multi-channel TDC timestamper: edge detect, pending slots,
//            priority arbiter and show-ahead record FIFO.
// Revision : 1.0
// ============================================================================
module tdc_stamp_engine
   import tdc_pkg::*;
#(
   parameter  int NUM_TAPS   = 32,
   parameter  int NUM_CH     = 2,
   parameter  int COARSE_W   = 16,
   parameter  int FIFO_DEPTH = 8,
   localparam int FINE_W     = tdc_fine_w(NUM_TAPS),
   localparam int CH_W       = tdc_ch_w(NUM_CH),
   localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic [NUM_CH*NUM_TAPS-1:0] taps_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [CH_W-1:0]            out_channel,
   output logic [COARSE_W-1:0]        out_coarse,
   output logic [FINE_W-1:0]          out_fine,
   output logic [NUM_CH-1:0]          dropped,
   output logic [LVL_W-1:0]           fifo_level
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [COARSE_W-1:0] r_coarse;
   logic [COARSE_W-1:0] r_s1_coarse;
   logic [NUM_TAPS-1:0] r_snap [NUM_CH];
   logic [NUM_TAPS-1:0] r_prev [NUM_CH];

   logic [NUM_CH-1:0]   r_pend_v;
   logic [COARSE_W-1:0] r_pend_coarse [NUM_CH];
   logic [FINE_W-1:0]   r_pend_fine   [NUM_CH];
   logic [NUM_CH-1:0]   r_dropped;

   tdc_rec_t            r_mem [FIFO_DEPTH];
   logic [AW-1:0]       r_wptr;
   logic [AW-1:0]       r_rptr;
   logic [LVL_W-1:0]    r_level;

   logic [FINE_W-1:0]   w_fine [NUM_CH];
   logic [NUM_CH-1:0]   w_event;
   logic [NUM_CH-1:0]   w_grant;
   logic                w_push;
   logic                w_pop;
   logic                w_can_push;
   tdc_rec_t            w_push_rec;
   tdc_rec_t            w_head;
   logic                w_unused;

   generate
      for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
         tdc_therm2bin #(.NUM_TAPS(NUM_TAPS)) u_pop (
            .i_therm (r_snap[c]),
            .o_count (w_fine[c])
         );
         // Rising arrival only: the line must have been fully clear the cycle before.
         assign w_event[c] = en && (|r_snap[c]) && !(|r_prev[c]);
      end
   endgenerate

   assign w_pop      = out_valid && out_ready;
   assign w_can_push = (r_level != LVL_W'(FIFO_DEPTH)) || w_pop;

   always_comb begin
      w_grant    = '0;
      w_push     = 1'b0;
      w_push_rec = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (r_pend_v[c] && !w_push && w_can_push) begin
            w_grant[c]        = 1'b1;
            w_push            = 1'b1;
            w_push_rec.channel = TDC_MAX_CH_W'(c);
            w_push_rec.coarse  = TDC_MAX_COARSE_W'(r_pend_coarse[c]);
            w_push_rec.fine    = TDC_MAX_FINE_W'(r_pend_fine[c]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_coarse    <= '0;
         r_s1_coarse <= '0;
         r_pend_v    <= '0;
         r_dropped   <= '0;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_level     <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            r_snap[c]        <= '0;
            r_prev[c]        <= '0;
            r_pend_coarse[c] <= '0;
            r_pend_fine[c]   <= '0;
         end
      end else begin
         if (en) begin
            r_coarse <= r_coarse + COARSE_W'(1);
         end
         r_s1_coarse <= r_coarse;
         for (int c = 0; c < NUM_CH; c++) begin
            r_snap[c] <= taps_in[c*NUM_TAPS +: NUM_TAPS];
            r_prev[c] <= r_snap[c];
            // A slot drained this cycle can take the new event immediately.
            if (w_event[c]) begin
               if (r_pend_v[c] && !w_grant[c]) begin
                  r_dropped[c] <= 1'b1;
               end else begin
                  r_pend_v[c]      <= 1'b1;
                  r_pend_coarse[c] <= r_s1_coarse;
                  r_pend_fine[c]   <= w_fine[c];
               end
            end else if (w_grant[c]) begin
               r_pend_v[c] <= 1'b0;
            end
         end
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         if (w_push && !w_pop) begin
            r_level <= r_level + LVL_W'(1);
         end else if (!w_push && w_pop) begin
            r_level <= r_level - LVL_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= w_push_rec;
      end
   end

   assign w_head      = r_mem[r_rptr];
   assign w_unused    = ^w_head;
   assign out_valid   = (r_level != '0);
   assign out_channel = w_head.channel[CH_W-1:0];
   assign out_coarse  = w_head.coarse[COARSE_W-1:0];
   assign out_fine    = w_head.fine[FINE_W-1:0];
   assign dropped     = r_dropped;
   assign fifo_level  = r_level;

endmodule
`default_nettype wire

// File: tb/tb_tdc_stamp_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdc_stamp_engine
// Brief    : Directed scoreboard bench; main instance plus a 4-bit-counter
//            instance for coarse wrap and enable-hold behaviour.
// Revision : 1.0
// ============================================================================
module tb_tdc_stamp_engine;

   typedef struct {
      int ch;
      int coarse;
      int fine;
      int cyc;
   } exp_t;

   logic clk;
   int   cyc;
   int   n_checks;
   int   n_errors;
   exp_t qa [$];
   exp_t qb [$];

   logic        a_rst, a_en, a_ready, a_valid;
   logic [63:0] a_taps;
   logic [0:0]  a_ch;
   logic [15:0] a_coarse;
   logic [5:0]  a_fine;
   logic [1:0]  a_dropped;
   logic [3:0]  a_level;

   logic        b_rst, b_en, b_ready, b_valid;
   logic [63:0] b_taps;
   logic [0:0]  b_ch;
   logic [3:0]  b_coarse;
   logic [5:0]  b_fine;
   logic [1:0]  b_dropped;
   logic [3:0]  b_level;

   logic [15:0] ma;
   logic [3:0]  mb;

   tdc_stamp_engine #(.NUM_TAPS(32), .NUM_CH(2), .COARSE_W(16), .FIFO_DEPTH(8)) u_dut (
      .clk (clk), .rst (a_rst), .en (a_en), .taps_in (a_taps),
      .out_valid (a_valid), .out_ready (a_ready), .out_channel (a_ch),
      .out_coarse (a_coarse), .out_fine (a_fine), .dropped (a_dropped),
      .fifo_level (a_level)
   );

   tdc_stamp_engine #(.NUM_TAPS(32), .NUM_CH(2), .COARSE_W(4), .FIFO_DEPTH(8)) u_wrap (
      .clk (clk), .rst (b_rst), .en (b_en), .taps_in (b_taps),
      .out_valid (b_valid), .out_ready (b_ready), .out_channel (b_ch),
      .out_coarse (b_coarse), .out_fine (b_fine), .dropped (b_dropped),
      .fifo_level (b_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference coarse counters driven only by the bench's own rst/en.
   always @(posedge clk) begin
      ma <= a_rst ? 16'd0 : (a_en ? ma + 16'd1 : ma);
      mb <= b_rst ? 4'd0 : (b_en ? mb + 4'd1 : mb);
   end

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_errors++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!a_rst && a_valid && a_ready) begin
         if (qa.size() == 0) begin
            chk("a_unexpected_record", 1, 0);
         end else begin
            e = qa.pop_front();
            chk("a_channel", int'(a_ch), e.ch);
            chk("a_coarse", int'(a_coarse), e.coarse);
            chk("a_fine", int'(a_fine), e.fine);
            if (e.cyc >= 0) chk("a_latency_cycle", cyc, e.cyc);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!b_rst && b_valid && b_ready) begin
         if (qb.size() == 0) begin
            chk("b_unexpected_record", 1, 0);
         end else begin
            e = qb.pop_front();
            chk("b_channel", int'(b_ch), e.ch);
            chk("b_coarse", int'(b_coarse), e.coarse);
            chk("b_fine", int'(b_fine), e.fine);
            if (e.cyc >= 0) chk("b_latency_cycle", cyc, e.cyc);
         end
      end
   end

   initial begin
      logic [31:0] mask;
      n_checks = 0;
      n_errors = 0;
      a_rst = 1'b1; a_en = 1'b0; a_ready = 1'b1; a_taps = '0;
      b_rst = 1'b1; b_en = 1'b0; b_ready = 1'b1; b_taps = '0;
      step();
      step();
      chk("rst_out_valid", int'(a_valid), 0);
      chk("rst_fifo_level", int'(a_level), 0);
      chk("rst_dropped", int'(a_dropped), 0);
      chk("rst_b_out_valid", int'(b_valid), 0);

      a_rst = 1'b0; b_rst = 1'b0; a_en = 1'b1;

      // Single event at counter 5, then held high: exactly one record.
      for (int i = 0; i < 50 && ma != 16'd5; i++) step();
      if (ma != 16'd5) chk("reach_count_5", int'(ma), 5);
      a_taps[31:0] = 32'h0000_00FF;
      qa.push_back('{0, 5, 8, cyc + 3});
      step();
      step();
      a_taps[31:0] = 32'hFFFF_FFFF;
      repeat (3) step();
      a_taps[31:0] = '0;
      step();

      // Bubbled snapshot on ch1.
      a_taps[63:32] = 32'h0000_00FB;
      qa.push_back('{1, int'(ma), 7, cyc + 3});
      step();
      a_taps[63:32] = 32'hFFFF_FFFF;
      repeat (3) step();
      a_taps = '0;
      repeat (2) step();

      // Simultaneous events at counter 20: ch0 first, ch1 one cycle later.
      for (int i = 0; i < 50 && ma != 16'd20; i++) step();
      if (ma != 16'd20) chk("reach_count_20", int'(ma), 20);
      a_taps = {32'h0000_00FF, 32'h0000_000F};
      qa.push_back('{0, 20, 4, cyc + 3});
      qa.push_back('{1, 20, 8, cyc + 4});
      step();
      a_taps = '0;
      repeat (6) step();
      chk("no_drop_yet", int'(a_dropped), 0);

      // Backpressure: 8 fill the FIFO, 9th waits pending, 10th is lost.
      a_ready = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         mask = (32'h1 << i) - 32'h1;
         a_taps[31:0] = mask;
         qa.push_back('{0, int'(ma), i, -1});
         step();
         a_taps = '0;
         step();
      end
      chk("bp_level_full", int'(a_level), 8);
      chk("bp_ninth_not_dropped", int'(a_dropped), 0);
      chk("bp_valid", int'(a_valid), 1);
      a_taps[31:0] = 32'h0000_03FF;
      step();
      a_taps = '0;
      step();
      step();
      chk("bp_tenth_dropped", int'(a_dropped), 1);
      chk("bp_level_still_full", int'(a_level), 8);
      a_ready = 1'b1;
      for (int i = 0; i < 60 && qa.size() != 0; i++) step();
      chk("bp_drain_remaining", qa.size(), 0);
      repeat (2) step();
      chk("bp_level_empty", int'(a_level), 0);
      chk("bp_dropped_sticky", int'(a_dropped), 1);

      // Reset with 3 records queued and ch1 still pending.
      a_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a_taps[31:0] = 32'h1;
         step();
         a_taps = '0;
         step();
      end
      a_taps[63:32] = 32'h1;
      step();
      a_taps = '0;
      step();
      chk("pre_rst_level", int'(a_level), 3);
      a_rst = 1'b1;
      step();
      chk("mid_rst_valid", int'(a_valid), 0);
      chk("mid_rst_level", int'(a_level), 0);
      chk("mid_rst_dropped", int'(a_dropped), 0);
      chk("mid_rst_counter", int'(u_dut.r_coarse), 0);
      a_rst = 1'b0;
      a_ready = 1'b1;
      a_taps[31:0] = 32'h3;
      qa.push_back('{0, 0, 2, cyc + 3});
      step();
      a_taps = '0;
      repeat (6) step();

      // Wrap on the 4-bit instance: 15, then 0, then 1.
      b_en = 1'b1;
      for (int i = 0; i < 40 && mb != 4'd15; i++) step();
      if (mb != 4'd15) chk("reach_b_count_15", int'(mb), 15);
      b_taps = {32'h0, 32'h1};
      qb.push_back('{0, 15, 1, cyc + 3});
      step();
      b_taps = {32'h1, 32'h0};
      qb.push_back('{1, 0, 1, cyc + 3});
      step();
      b_taps = {32'h1, 32'h1};
      qb.push_back('{0, 1, 1, cyc + 3});
      step();
      b_taps = '0;
      repeat (2) step();

      // en=0 for three cycles: counter holds at 4, rising snapshot ignored.
      b_en = 1'b0;
      b_taps[31:0] = 32'hF;
      step();
      step();
      chk("en0_counter_hold", int'(u_wrap.r_coarse), 4);
      step();
      b_en = 1'b1;
      b_taps = '0;
      step();
      b_taps[31:0] = 32'h1;
      qb.push_back('{0, 5, 1, cyc + 3});
      step();
      b_taps = '0;
      repeat (6) step();

      for (int i = 0; i < 40 && (qa.size() != 0 || qb.size() != 0); i++) step();
      chk("final_a_outstanding", qa.size(), 0);
      chk("final_b_outstanding", qb.size(), 0);
      chk("final_b_dropped", int'(b_dropped), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
